// File: rtl/dcache_mem_ctlr_pkg.sv
// Shared types for the dcache-to-memory-controller protocol: bus commands,
// in-flight entry layout and the tag sequence helper.
package dcache_mem_ctlr_pkg;

    localparam int XLEN         = 32;
    localparam int MEMCTLR_TAGS = 15;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef struct packed {
        logic       valid;
        logic [3:0] tag;
        BUS_COMMAND command;
        logic [63:0] data;
        logic [3:0] age;
    } MEMCTLR_ENTRY_PACKET;

    // Tags run 1..15 and wrap to 1; tag 0 means "no response".
    function automatic logic [3:0] next_tag_f(input logic [3:0] tag);
        return (tag == 4'(MEMCTLR_TAGS)) ? 4'd1 : tag + 4'd1;
    endfunction

endpackage

// File: rtl/dcache_mem_ctlr_if.sv
// Request/response bundle between the dcache MSHR issue port and the memory controller.
interface dcache_mem_ctlr_if;
    import dcache_mem_ctlr_pkg::*;

    // Handshake: a command is taken in the cycle it is presented iff
    // ctlr2proc_response is nonzero that same cycle (the value is the tag);
    // a zero response means refused, and the requester must re-present it.
    // Completion is signalled by a nonzero ctlr2proc_tag for exactly one cycle.
    BUS_COMMAND       proc2ctlr_command;
    logic [XLEN-1:0]  proc2ctlr_addr;
    logic [63:0]      proc2ctlr_data;
    logic             cfg_stall;
    logic             cfg_hold;
    logic [3:0]       ctlr2proc_response;
    logic [3:0]       ctlr2proc_tag;
    logic [63:0]      ctlr2proc_data;
    logic [3:0]       inflight_cnt;

    modport master (
        output proc2ctlr_command, proc2ctlr_addr, proc2ctlr_data, cfg_stall, cfg_hold,
        input  ctlr2proc_response, ctlr2proc_tag, ctlr2proc_data, inflight_cnt
    );

    modport slave (
        input  proc2ctlr_command, proc2ctlr_addr, proc2ctlr_data, cfg_stall, cfg_hold,
        output ctlr2proc_response, ctlr2proc_tag, ctlr2proc_data, inflight_cnt
    );

endinterface

// File: rtl/dcache_mem_ctlr_inflight_fifo.sv
// Circular 15-entry FIFO of accepted requests with parallel saturating ageing;
// head_ready flags the oldest entry once it has served its latency.
module memctlr_inflight_fifo
    import dcache_mem_ctlr_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_push,
    input  MEMCTLR_ENTRY_PACKET i_push_entry,
    input  logic                i_pop,
    output logic [3:0]          o_head_tag,
    output BUS_COMMAND          o_head_command,
    output logic [63:0]         o_head_data,
    output logic                o_head_ready,
    output logic [3:0]          o_count
);

    localparam logic [3:0] LAT_W  = 4'(LATENCY);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    MEMCTLR_ENTRY_PACKET r_entries [MEMCTLR_TAGS];
    logic [3:0] r_head;
    logic [3:0] r_tail;
    logic [3:0] r_count;

    function automatic logic [3:0] ptr_inc(input logic [3:0] p);
        return (p == 4'(MEMCTLR_TAGS - 1)) ? 4'd0 : p + 4'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= 4'd0;
            r_tail  <= 4'd0;
            r_count <= 4'd0;
            for (int i = 0; i < MEMCTLR_TAGS; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MEMCTLR_TAGS; i++) begin
                if (r_entries[i].valid && (r_entries[i].age < LAT_W)) begin
                    r_entries[i].age <= r_entries[i].age + 4'd1;
                end
            end
            if (i_pop) begin
                r_entries[r_head].valid <= 1'b0;
                r_head                  <= ptr_inc(r_head);
            end
            // The tail slot is always free when a push is allowed, so it never
            // collides with the ageing or pop updates above.
            if (i_push) begin
                r_entries[r_tail] <= i_push_entry;
                r_tail            <= ptr_inc(r_tail);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Age already counts the accept cycle, so LATENCY-1 here yields a
    // registered completion LATENCY cycles after the accept.
    assign o_head_tag     = r_entries[r_head].tag;
    assign o_head_command = r_entries[r_head].command;
    assign o_head_data    = r_entries[r_head].data;
    assign o_head_ready   = r_entries[r_head].valid && (r_entries[r_head].age >= LAT_M1);
    assign o_count        = r_count;

endmodule

// File: rtl/dcache_mem_ctlr.sv
// Memory-controller responder for the dcache: accepts tagged loads/stores,
// keeps a private 64-bit backing store and completes requests in order.
module dcache_mem_ctlr
    import dcache_mem_ctlr_pkg::*;
#(
    parameter int MEM_DEPTH_W = 10,
    parameter int LATENCY     = 4
) (
    input  logic            clock,
    input  logic            reset,
    dcache_mem_ctlr_if.slave bus
);

    localparam int MEM_WORDS = 1 << MEM_DEPTH_W;

    logic [63:0] r_mem [MEM_WORDS];
    logic [3:0]  r_next_tag;
    logic [3:0]  r_tag;
    logic [63:0] r_data;

    logic                   w_accept;
    logic                   w_is_load;
    logic                   w_is_store;
    logic                   w_bypass;
    logic                   w_push;
    logic                   w_pop;
    logic [MEM_DEPTH_W-1:0] w_index;
    logic [63:0]            w_rd_data;
    MEMCTLR_ENTRY_PACKET    w_push_entry;
    logic [3:0]             w_head_tag;
    BUS_COMMAND             w_head_command;
    logic [63:0]            w_head_data;
    logic                   w_head_ready;
    logic [3:0]             w_count;
    logic                   w_unused_addr;

    // Upper address bits alias onto the same words; byte offset is ignored.
    assign w_index       = bus.proc2ctlr_addr[MEM_DEPTH_W+2:3];
    assign w_unused_addr = ^{bus.proc2ctlr_addr[XLEN-1:MEM_DEPTH_W+3], bus.proc2ctlr_addr[2:0]};
    assign w_rd_data     = r_mem[w_index];

    // Full is judged on the pre-edge count, so a same-edge pop cannot make room.
    assign w_accept   = reset && (bus.proc2ctlr_command != BUS_NONE) && !bus.cfg_stall &&
                        (w_count < 4'(MEMCTLR_TAGS));
    assign w_is_load  = w_accept && (bus.proc2ctlr_command == BUS_LOAD);
    assign w_is_store = w_accept && (bus.proc2ctlr_command == BUS_STORE);

    // With single-cycle latency an idle controller completes straight from accept.
    assign w_bypass = (LATENCY == 1) && w_accept && (w_count == 4'd0) && !bus.cfg_hold;
    assign w_push   = w_accept && !w_bypass;
    assign w_pop    = w_head_ready && !bus.cfg_hold;

    always_comb begin
        w_push_entry         = '0;
        w_push_entry.valid   = 1'b1;
        w_push_entry.tag     = r_next_tag;
        w_push_entry.command = bus.proc2ctlr_command;
        w_push_entry.data    = w_is_load ? w_rd_data : 64'd0;
        w_push_entry.age     = 4'd1;
    end

    memctlr_inflight_fifo #(
        .LATENCY (LATENCY)
    ) u_fifo (
        .clk            (clock),
        .rst_n          (reset),
        .i_push         (w_push),
        .i_push_entry   (w_push_entry),
        .i_pop          (w_pop),
        .o_head_tag     (w_head_tag),
        .o_head_command (w_head_command),
        .o_head_data    (w_head_data),
        .o_head_ready   (w_head_ready),
        .o_count        (w_count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                r_mem[i] <= 64'd0;
            end
        end else if (w_is_store) begin
            r_mem[w_index] <= bus.proc2ctlr_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_next_tag <= 4'd1;
            r_tag      <= 4'd0;
            r_data     <= 64'd0;
        end else begin
            if (w_accept) begin
                r_next_tag <= next_tag_f(r_next_tag);
            end
            if (w_pop) begin
                r_tag  <= w_head_tag;
                r_data <= (w_head_command == BUS_LOAD) ? w_head_data : 64'd0;
            end else if (w_bypass) begin
                r_tag  <= r_next_tag;
                r_data <= w_is_load ? w_rd_data : 64'd0;
            end else begin
                r_tag  <= 4'd0;
                r_data <= 64'd0;
            end
        end
    end

    assign bus.ctlr2proc_response = w_accept ? r_next_tag : 4'd0;
    assign bus.ctlr2proc_tag      = r_tag;
    assign bus.ctlr2proc_data     = r_data;
    assign bus.inflight_cnt       = w_count;

endmodule

// File: tb/tb_dcache_mem_ctlr.sv
// Directed bench for dcache_mem_ctlr at MEM_DEPTH_W=10, LATENCY=4.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_dcache_mem_ctlr;
    import dcache_mem_ctlr_pkg::*;

    logic clock;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;

    dcache_mem_ctlr_if bus();

    dcache_mem_ctlr #(
        .MEM_DEPTH_W (10),
        .LATENCY     (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input BUS_COMMAND cmd, input logic [31:0] addr, input logic [63:0] data);
        bus.proc2ctlr_command = cmd;
        bus.proc2ctlr_addr    = addr;
        bus.proc2ctlr_data    = data;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset         = 1'b0;
        bus.cfg_stall = 1'b0;
        bus.cfg_hold  = 1'b0;
        drive(BUS_NONE, 32'd0, 64'd0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        bus.cfg_stall = 1'b0;
        bus.cfg_hold  = 1'b0;
        drive(BUS_LOAD, 32'h0000_0010, 64'd0);
        #1;
        n_total++;
        if (bus.ctlr2proc_response !== 4'd0) $display("FAIL reset_resp: got %0d expected 0", bus.ctlr2proc_response); else n_pass++;
        @(negedge clock); #1;
        n_total++;
        if (bus.ctlr2proc_tag !== 4'd0) $display("FAIL reset_tag: got %0d expected 0", bus.ctlr2proc_tag); else n_pass++;
        n_total++;
        if (bus.ctlr2proc_data !== 64'd0) $display("FAIL reset_data: got %h expected 0", bus.ctlr2proc_data); else n_pass++;
        n_total++;
        if (bus.inflight_cnt !== 4'd0) $display("FAIL reset_cnt: got %0d expected 0", bus.inflight_cnt); else n_pass++;
        drive(BUS_NONE, 32'd0, 64'd0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_store_load();
        do_reset();
        @(negedge clock); drive(BUS_STORE, 32'h0000_0010, 64'hDEADBEEF_01234567); #1;
        n_total++;
        if (bus.ctlr2proc_response !== 4'd1) $display("FAIL sl_resp0: got %0d expected 1", bus.ctlr2proc_response); else n_pass++;
        @(negedge clock); drive(BUS_LOAD, 32'h0000_0010, 64'd0); #1;
        n_total++;
        if (bus.ctlr2proc_response !== 4'd2) $display("FAIL sl_resp1: got %0d expected 2", bus.ctlr2proc_response); else n_pass++;
        n_total++;
        if (bus.inflight_cnt !== 4'd1) $display("FAIL sl_cnt1: got %0d expected 1", bus.inflight_cnt); else n_pass++;
        @(negedge clock); drive(BUS_NONE, 32'd0, 64'd0); #1;
        n_total++;
        if (bus.ctlr2proc_tag !== 4'd0) $display("FAIL sl_tag2: got %0d expected 0", bus.ctlr2proc_tag); else n_pass++;
        @(negedge clock); #1;
        n_total++;
        if (bus.ctlr2proc_tag !== 4'd0) $display("FAIL sl_tag3: got %0d expected 0", bus.ctlr2proc_tag); else n_pass++;
        @(negedge clock); #1;
        n_total++;
        if (bus.ctlr2proc_tag !== 4'd1) $display("FAIL sl_tag4: got %0d expected 1", bus.ctlr2proc_tag); else n_pass++;
        n_total++;
        if (bus.ctlr2proc_data !== 64'd0) $display("FAIL sl_data4: got %h expected 0", bus.ctlr2proc_data); else n_pass++;
        @(negedge clock); #1;
        n_total++;
        if (bus.ctlr2proc_tag !== 4'd2) $display("FAIL sl_tag5: got %0d expected 2", bus.ctlr2proc_tag); else n_pass++;
        n_total++;
        if (bus.ctlr2proc_data !== 64'hDEADBEEF_01234567) $display("FAIL sl_data5: got %h expected deadbeef01234567", bus.ctlr2proc_data); else n_pass++;
        @(negedge clock); #1;
        n_total++;
        if (bus.ctlr2proc_tag !== 4'd0) $display("FAIL sl_tag6: got %0d expected 0", bus.ctlr2proc_tag); else n_pass++;
        n_total++;
        if (bus.inflight_cnt !== 4'd0) $display("FAIL sl_cnt6: got %0d expected 0", bus.inflight_cnt); else n_pass++;
    endtask

    task automatic test_tag_wrap();
        logic [3:0] exp_resp;
        logic [3:0] exp_tag;
        do_reset();
        for (int c = 0; c < 21; c++) begin
            @(negedge clock);
            if (c < 16) drive(BUS_LOAD, 32'(c * 8), 64'd0);
            else        drive(BUS_NONE, 32'd0, 64'd0);
            #1;
            if (c < 16) begin
                exp_resp = 4'((c % 15) + 1);
                n_total++;
                if (bus.ctlr2proc_response !== exp_resp) $display("FAIL wrap_resp c=%0d: got %0d expected %0d", c, bus.ctlr2proc_response, exp_resp); else n_pass++;
            end
            exp_tag = (c >= 4 && c < 20) ? 4'(((c - 4) % 15) + 1) : 4'd0;
            n_total++;
            if (bus.ctlr2proc_tag !== exp_tag) $display("FAIL wrap_tag c=%0d: got %0d expected %0d", c, bus.ctlr2proc_tag, exp_tag); else n_pass++;
        end
    endtask

    task automatic test_full();
        logic [3:0] exp_tag;
        do_reset();
        bus.cfg_hold = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clock); drive(BUS_STORE, 32'(c * 8), 64'(c + 100)); #1;
            n_total++;
            if (bus.ctlr2proc_response !== ((c < 15) ? 4'(c + 1) : 4'd0)) $display("FAIL full_resp c=%0d: got %0d expected %0d", c, bus.ctlr2proc_response, (c < 15) ? c + 1 : 0); else n_pass++;
        end
        n_total++;
        if (bus.inflight_cnt !== 4'd15) $display("FAIL full_cnt: got %0d expected 15", bus.inflight_cnt); else n_pass++;
        n_total++;
        if (bus.ctlr2proc_tag !== 4'd0) $display("FAIL full_hold_tag: got %0d expected 0", bus.ctlr2proc_tag); else n_pass++;
        @(negedge clock); bus.cfg_hold = 1'b0; #1;
        n_total++;
        if (bus.ctlr2proc_response !== 4'd0) $display("FAIL full_release_resp: got %0d expected 0", bus.ctlr2proc_response); else n_pass++;
        for (int c = 17; c < 34; c++) begin
            @(negedge clock);
            if (c > 17) drive(BUS_NONE, 32'd0, 64'd0);
            #1;
            if (c == 17) begin
                n_total++;
                if (bus.ctlr2proc_response !== 4'd1) $display("FAIL full_retry_resp: got %0d expected 1", bus.ctlr2proc_response); else n_pass++;
                n_total++;
                if (bus.inflight_cnt !== 4'd14) $display("FAIL full_cnt17: got %0d expected 14", bus.inflight_cnt); else n_pass++;
            end
            exp_tag = (c <= 31) ? 4'(c - 16) : ((c == 32) ? 4'd1 : 4'd0);
            n_total++;
            if (bus.ctlr2proc_tag !== exp_tag) $display("FAIL full_tag c=%0d: got %0d expected %0d", c, bus.ctlr2proc_tag, exp_tag); else n_pass++;
        end
        n_total++;
        if (bus.inflight_cnt !== 4'd0) $display("FAIL full_cnt_end: got %0d expected 0", bus.inflight_cnt); else n_pass++;
    endtask

    task automatic test_stall();
        logic [3:0] exp_tag;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            bus.cfg_stall = (c >= 1 && c <= 3);
            if (c <= 4) drive(BUS_LOAD, 32'h0000_0018, 64'd0);
            else        drive(BUS_NONE, 32'd0, 64'd0);
            #1;
            if (c <= 4) begin
                n_total++;
                if (bus.ctlr2proc_response !== ((c == 0) ? 4'd1 : (c == 4) ? 4'd2 : 4'd0)) $display("FAIL stall_resp c=%0d: got %0d", c, bus.ctlr2proc_response); else n_pass++;
            end
            if (c >= 1 && c <= 3) begin
                n_total++;
                if (bus.inflight_cnt !== 4'd1) $display("FAIL stall_cnt c=%0d: got %0d expected 1", c, bus.inflight_cnt); else n_pass++;
            end
            exp_tag = (c == 4) ? 4'd1 : ((c == 8) ? 4'd2 : 4'd0);
            n_total++;
            if (bus.ctlr2proc_tag !== exp_tag) $display("FAIL stall_tag c=%0d: got %0d expected %0d", c, bus.ctlr2proc_tag, exp_tag); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clock); drive(BUS_STORE, 32'h0000_0040, 64'h0000_0000_0000_ABCD); #1;
        n_total++;
        if (bus.ctlr2proc_response !== 4'd1) $display("FAIL rm_store_resp: got %0d expected 1", bus.ctlr2proc_response); else n_pass++;
        @(negedge clock); drive(BUS_NONE, 32'd0, 64'd0);
        for (int c = 2; c < 5; c++) begin
            @(negedge clock); drive(BUS_LOAD, 32'h0000_0040, 64'd0); #1;
            n_total++;
            if (bus.ctlr2proc_response !== 4'(c)) $display("FAIL rm_load_resp c=%0d: got %0d expected %0d", c, bus.ctlr2proc_response, c); else n_pass++;
        end
        @(negedge clock); reset = 1'b0; #1;
        n_total++;
        if (bus.ctlr2proc_response !== 4'd0) $display("FAIL rm_resp_in_reset: got %0d expected 0", bus.ctlr2proc_response); else n_pass++;
        n_total++;
        if (bus.ctlr2proc_tag !== 4'd0) $display("FAIL rm_tag_in_reset: got %0d expected 0", bus.ctlr2proc_tag); else n_pass++;
        n_total++;
        if (bus.inflight_cnt !== 4'd0) $display("FAIL rm_cnt_in_reset: got %0d expected 0", bus.inflight_cnt); else n_pass++;
        @(negedge clock); reset = 1'b1; drive(BUS_NONE, 32'd0, 64'd0);
        for (int c = 6; c < 10; c++) begin
            #1;
            n_total++;
            if (bus.ctlr2proc_tag !== 4'd0) $display("FAIL rm_no_completion c=%0d: got %0d expected 0", c, bus.ctlr2proc_tag); else n_pass++;
            @(negedge clock);
        end
        drive(BUS_LOAD, 32'h0000_0040, 64'd0); #1;
        n_total++;
        if (bus.ctlr2proc_response !== 4'd1) $display("FAIL rm_first_tag: got %0d expected 1", bus.ctlr2proc_response); else n_pass++;
        @(negedge clock); drive(BUS_NONE, 32'd0, 64'd0);
        repeat (3) @(negedge clock);
        #1;
        n_total++;
        if (bus.ctlr2proc_tag !== 4'd1) $display("FAIL rm_reload_tag: got %0d expected 1", bus.ctlr2proc_tag); else n_pass++;
        n_total++;
        if (bus.ctlr2proc_data !== 64'd0) $display("FAIL rm_reload_data: got %h expected 0", bus.ctlr2proc_data); else n_pass++;
    endtask

    task automatic test_alias();
        do_reset();
        @(negedge clock); drive(BUS_STORE, 32'h0000_2008, 64'h55); #1;
        n_total++;
        if (bus.ctlr2proc_response !== 4'd1) $display("FAIL alias_store_resp: got %0d expected 1", bus.ctlr2proc_response); else n_pass++;
        @(negedge clock); drive(BUS_LOAD, 32'h0000_0008, 64'd0); #1;
        n_total++;
        if (bus.ctlr2proc_response !== 4'd2) $display("FAIL alias_load_resp: got %0d expected 2", bus.ctlr2proc_response); else n_pass++;
        @(negedge clock); drive(BUS_LOAD, 32'h0000_0010, 64'd0);
        @(negedge clock); drive(BUS_NONE, 32'd0, 64'd0);
        @(negedge clock);
        @(negedge clock); #1;
        n_total++;
        if (bus.ctlr2proc_tag !== 4'd2) $display("FAIL alias_tag: got %0d expected 2", bus.ctlr2proc_tag); else n_pass++;
        n_total++;
        if (bus.ctlr2proc_data !== 64'h55) $display("FAIL alias_data: got %h expected 55", bus.ctlr2proc_data); else n_pass++;
        @(negedge clock); #1;
        n_total++;
        if (bus.ctlr2proc_tag !== 4'd3) $display("FAIL alias_other_tag: got %0d expected 3", bus.ctlr2proc_tag); else n_pass++;
        n_total++;
        if (bus.ctlr2proc_data !== 64'd0) $display("FAIL alias_other_data: got %h expected 0", bus.ctlr2proc_data); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_data;
        logic [3:0]  exp_tag;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            @(negedge clock);
            if (c < 3)      drive(BUS_STORE, 32'((c + 1) * 8), 64'hA5A5_0000_0000_0000 | 64'(c + 1));
            else if (c < 6) drive(BUS_LOAD, 32'((c - 2) * 8), 64'd0);
            else            drive(BUS_NONE, 32'd0, 64'd0);
            #1;
            if (c < 6) begin
                n_total++;
                if (bus.ctlr2proc_response !== 4'(c + 1)) $display("FAIL b2b_resp c=%0d: got %0d expected %0d", c, bus.ctlr2proc_response, c + 1); else n_pass++;
            end
            exp_tag  = (c >= 4 && c <= 9) ? 4'(c - 3) : 4'd0;
            exp_data = (c >= 7 && c <= 9) ? (64'hA5A5_0000_0000_0000 | 64'(c - 6)) : 64'd0;
            n_total++;
            if (bus.ctlr2proc_tag !== exp_tag) $display("FAIL b2b_tag c=%0d: got %0d expected %0d", c, bus.ctlr2proc_tag, exp_tag); else n_pass++;
            n_total++;
            if (bus.ctlr2proc_data !== exp_data) $display("FAIL b2b_data c=%0d: got %h expected %h", c, bus.ctlr2proc_data, exp_data); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_tag_wrap();
        test_full();
        test_stall();
        test_reset_mid();
        test_alias();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
